// File: rtl/stream_pool2x2_pkg.sv
// Shared types and helpers for the streaming 2x2 pooling stage.
//   pool_mode_e : pooling mode (MODE_MAX / MODE_AVG)
//   comb_t      : wide signed type for the pair/quad combine datapath
//   combine()   : max or sum of two sign-extended operands
package stream_pool2x2_pkg;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    // Wide enough for DATA_W up to 32 plus two growth bits for a 4-value sum.
    localparam int unsigned COMB_W = 34;

    typedef logic signed [COMB_W-1:0] comb_t;

    function automatic comb_t combine(input comb_t a, input comb_t b, input pool_mode_e mode);
        if (mode == MODE_AVG) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stream_pool2x2_if.sv
// Stream bundle for the pooling stage: pixel input and pooled-result output handshakes.
//   in_valid/in_ready/in_data          : pixel stream into the pool
//   out_valid/out_ready/out_data/out_last : pooled results out of the pool
// Modports: slave = the pooling block, master = the environment driving/consuming it.
interface stream_pool2x2_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/stream_pool2x2_line_buf.sv
// Line buffer holding the horizontal pair results of an even row until the odd row arrives.
//   clk_i   : clock
//   we_i    : synchronous write enable
//   waddr_i : write address (col >> 1)
//   wdata_i : pair result to store
//   raddr_i : combinational read address (col >> 1)
//   rdata_o : stored pair result
// Contents are not reset: every entry is written in the even row before the odd row reads it.
module stream_pool2x2_line_buf #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 10,
    parameter int unsigned AddrW = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_pool2x2.sv
// Streaming 2x2 stride-2 pooling stage (max or average) over a row-major single-channel frame.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, dominates en and handshakes
//   en   : global enable; low freezes all state and drops in_ready
//   mode : 0 = max, 1 = average; latched on the accept of pixel (0,0)
//   bus  : slave side of the stream bundle (pixel in, pooled result out with out_last)
// A result is registered on the edge that accepts the bottom-right pixel of a window.
module stream_pool2x2
    import stream_pool2x2_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic             mode,
    stream_pool2x2_if.slave bus
);

    localparam int unsigned W2     = DATA_W + 2;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned DEPTH  = IMG_W / 2;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
        $error("stream_pool2x2: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
        $error("stream_pool2x2: IMG_H must be even and >= 2");
    end
    if ((DATA_W < 2) || (DATA_W > COMB_W - 2)) begin : g_bad_data_w
        $error("stream_pool2x2: DATA_W out of supported range");
    end

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    pool_mode_e               mode_q, mode_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;

    logic                     in_ready;
    logic                     in_acc;
    logic                     out_acc;
    logic                     res_load;
    logic                     buf_we;
    logic [ADDR_W-1:0]        buf_addr;
    logic [W2-1:0]            buf_wdata;
    logic [W2-1:0]            buf_rdata;

    comb_t                    pix_ext;
    comb_t                    hold_ext;
    comb_t                    buf_ext;
    comb_t                    pair;
    comb_t                    quad;
    comb_t                    quad_avg;
    logic signed [DATA_W-1:0] res;

    // A pending result blocks input so it can never be overwritten before it is taken.
    assign in_ready = en & (~out_valid_q | bus.out_ready);
    assign in_acc   = bus.in_valid & in_ready;
    assign out_acc  = out_valid_q & bus.out_ready;

    assign buf_addr = ADDR_W'(col_q >> 1);
    assign buf_we   = in_acc & col_q[0] & ~row_q[0];
    assign res_load = in_acc & col_q[0] & row_q[0];

    always_comb begin
        pix_ext   = comb_t'(bus.in_data);
        hold_ext  = comb_t'(hold_q);
        buf_ext   = comb_t'($signed(buf_rdata));
        pair      = combine(hold_ext, pix_ext, mode_q);
        quad      = combine(buf_ext, pair, mode_q);
        // Arithmetic shift floors toward -inf; the quotient always fits back in DATA_W.
        quad_avg  = quad >>> 2;
        buf_wdata = W2'(pair);
        if (mode_q == MODE_AVG) begin
            res = DATA_W'(quad_avg);
        end else begin
            res = DATA_W'(quad);
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (in_acc) begin
            if ((col_q == '0) && (row_q == '0)) begin
                mode_d = pool_mode_e'(mode);
            end
            if (!col_q[0]) begin
                hold_d = bus.in_data;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        if (res_load) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
        end else if (out_acc) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_MAX;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (en) begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    stream_pool2x2_line_buf #(
        .Depth (DEPTH),
        .Width (W2),
        .AddrW (ADDR_W)
    ) u_line_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (buf_addr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_addr),
        .rdata_o (buf_rdata)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_pool2x2.sv
// Self-checking bench for stream_pool2x2 (DATA_W=8, IMG_W=4, IMG_H=2).
// A reference model keeps each frame as a 2-D pixel array and computes every window's
// max / floor-average directly; a per-cycle monitor compares handshakes and results.
module tb_stream_pool2x2;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic mode;

    stream_pool2x2_if #(.DATA_W(DATA_W)) bus ();

    stream_pool2x2 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // out_ready policy: 0 = low, 1 = high, 2 = random
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Reference model
    exp_t exp_q[$];
    int   got_q[$];
    bit   got_last_q[$];
    int   px[IMG_H][IMG_W];
    int   m_x = 0;
    int   m_y = 0;
    bit   m_avg = 1'b0;
    int   n_last = 0;
    bit   mon_en = 1'b0;

    function automatic int floor_div4(input int s);
        int q;
        q = s / 4;
        if ((s % 4 != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_accept(input int v, input bit m);
        int a, b, c, d, r;
        exp_t e;
        if (m_x == 0 && m_y == 0) m_avg = m;
        px[m_y][m_x] = v;
        if ((m_x % 2 == 1) && (m_y % 2 == 1)) begin
            a = px[m_y-1][m_x-1];
            b = px[m_y-1][m_x];
            c = px[m_y][m_x-1];
            d = px[m_y][m_x];
            if (m_avg) begin
                r = floor_div4(a + b + c + d);
            end else begin
                r = a;
                if (b > r) r = b;
                if (c > r) r = c;
                if (d > r) r = d;
            end
            e.data = r;
            e.last = (m_x == IMG_W - 1) && (m_y == IMG_H - 1);
            exp_q.push_back(e);
        end
        m_x++;
        if (m_x == IMG_W) begin
            m_x = 0;
            m_y = (m_y + 1) % IMG_H;
        end
    endtask

    // Compare at the negedge, then apply what the next rising edge will do.
    always @(negedge clk) begin
        bit ev;
        if (mon_en) begin
            ev = (exp_q.size() != 0);
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            check("in_ready", 32'(bus.in_ready), 32'(en & (~ev | bus.out_ready)));
            if (ev && bus.out_valid) begin
                check("out_data", 32'(int'(bus.out_data)), 32'(exp_q[0].data));
                check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
            end
        end
        if (rst) begin
            exp_q.delete();
            m_x = 0;
            m_y = 0;
        end else if (en) begin
            // A frozen block (en=0) completes no transfer.
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got_q.push_back(int'(bus.out_data));
                got_last_q.push_back(bus.out_last);
                if (bus.out_last) n_last++;
            end
            if (bus.in_valid && bus.in_ready) model_accept(int'(bus.in_data), mode);
        end
    end

    // Stimulus helpers
    logic signed [7:0] frame_px[NPIX];
    int dir_frame[NPIX] = '{2, -2, 0, 4, 1, 3, -5, -1};

    task automatic load_dir_frame();
        for (int i = 0; i < NPIX; i++) frame_px[i] = dir_frame[i][7:0];
    endtask

    task automatic push_pix(input logic signed [7:0] v);
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_range(input int from, input int upto, input bit gaps, input bit toggle);
        for (int i = from; i < upto; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            if (gaps && $urandom_range(0, 7) == 0) begin
                en = 1'b0;
                @(posedge clk);
                #1;
                en = 1'b1;
            end
            push_pix(frame_px[i]);
            if (toggle) mode = ~mode;
        end
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_two(input string tag, input int v0, input int v1);
        check({tag, "_count"}, 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check({tag, "_r0"}, 32'(got_q[0]), 32'(v0));
            check({tag, "_r1"}, 32'(got_q[1]), 32'(v1));
            check({tag, "_last0"}, 32'(got_last_q[0]), 32'd0);
            check({tag, "_last1"}, 32'(got_last_q[1]), 32'd1);
        end
    endtask

    task automatic clear_got();
        got_q.delete();
        got_last_q.delete();
    endtask

    initial begin
        int base_last;
        rst          = 1'b1;
        en           = 1'b1;
        mode         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Max mode, directed frame
        clear_got();
        load_dir_frame();
        mode = 1'b0;
        send_range(0, NPIX, 1'b0, 1'b0);
        drain();
        expect_two("max", 3, 4);

        // Average mode, same frame
        clear_got();
        mode = 1'b1;
        send_range(0, NPIX, 1'b0, 1'b0);
        drain();
        expect_two("avg", 1, -1);

        // All -128 in both modes
        for (int m = 0; m < 2; m++) begin
            clear_got();
            for (int i = 0; i < NPIX; i++) frame_px[i] = 8'sh80;
            mode = m[0];
            send_range(0, NPIX, 1'b0, 1'b0);
            drain();
            expect_two(m == 0 ? "neg_max" : "neg_avg", -128, -128);
        end

        // Backpressure after the first result
        clear_got();
        load_dir_frame();
        mode = 1'b0;
        send_range(0, 5, 1'b0, 1'b0);
        ready_mode = 0;
        push_pix(frame_px[5]);
        bus.in_valid = 1'b1;
        bus.in_data  = frame_px[6];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(int'(bus.out_data)), 32'(3));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        ready_mode = 1;
        send_range(6, NPIX, 1'b0, 1'b0);
        drain();
        expect_two("bp", 3, 4);

        // en low for 5 cycles mid-frame with a pending result and in_valid high
        clear_got();
        send_range(0, 6, 1'b0, 1'b0);
        en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = frame_px[6];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_in_ready", 32'(bus.in_ready), 32'd0);
            check("en_hold_valid", 32'(bus.out_valid), 32'd1);
            check("en_hold_data", 32'(int'(bus.out_data)), 32'(3));
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        send_range(6, NPIX, 1'b0, 1'b0);
        drain();
        expect_two("en_pause", 3, 4);

        // Reset after three pixels of row 1
        for (int i = 0; i < NPIX; i++) frame_px[i] = 8'($urandom);
        send_range(0, IMG_W + 3, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        clear_got();
        load_dir_frame();
        mode = 1'b0;
        send_range(0, NPIX, 1'b0, 1'b0);
        drain();
        expect_two("after_rst", 3, 4);

        // Mode toggled after every pixel: the value at pixel (0,0) rules the frame
        clear_got();
        mode = 1'b1;
        send_range(0, NPIX, 1'b0, 1'b1);
        drain();
        expect_two("mode_toggle", 1, -1);

        // Random back-to-back frames with backpressure, gaps and enable drops
        base_last  = n_last;
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                case ($urandom_range(0, 7))
                    0:       frame_px[i] = 8'sh80;
                    1:       frame_px[i] = 8'sh7f;
                    default: frame_px[i] = 8'($urandom);
                endcase
            end
            mode = $urandom_range(0, 1) != 0;
            send_range(0, NPIX, f >= 10, f >= 20);
        end
        drain();
        check("last_per_frame", 32'(n_last - base_last), 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
